// File: rtl/spi_defs_pkg.sv
// Shared definitions for the SPI master: frame geometry, FSM encoding and
// the data-phase bit classifier used by both shift paths.
package spi_defs;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // True while the frame is in its data half (bits 8..15).
    function automatic logic is_data_bit(input logic [4:0] bitcnt);
        return (bitcnt >= 5'(DATA_BITS)) && (bitcnt < 5'(FRAME_BITS));
    endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SCLK generator: half-period counter, registered sclk and one-cycle
// rise/fall strobes that line up with the clk edge where sclk toggles.
module spi_sclk_gen
    import spi_defs::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt_r;
    logic       sclk_r;
    logic       toggle_s;

    assign toggle_s = en && (cnt_r == 8'(CLKDIV - 1));
    assign rise     = toggle_s && !sclk_r;
    assign fall     = toggle_s && sclk_r;
    assign sclk     = sclk_r;

    // Half-period counter; sclk parks low whenever the generator is disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (toggle_s) begin
            cnt_r  <= 8'd0;
            sclk_r <= ~sclk_r;
        end else begin
            cnt_r  <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one 16-bit {rw, addr, data} frame per accepted start.
// Framing, shift registers and outputs live here; SCLK timing in spi_sclk_gen.
module spi_master_ctrl
    import spi_defs::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 miso,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi
);

    localparam logic [7:0] PHASE_LAST = 8'(CLKDIV - 1);

    spi_state_t            state_r, state_s;
    logic [FRAME_BITS-1:0] tx_r, tx_s;
    logic [DATA_BITS-1:0]  rx_r, rx_s;
    logic [DATA_BITS-1:0]  rdata_r, rdata_s;
    logic [4:0]            bitcnt_r, bitcnt_s;
    logic [7:0]            phase_r, phase_s;
    logic                  rw_r, rw_s;
    logic                  busy_r, done_r, cs_n_r, mosi_r;
    logic                  done_s, mosi_s;
    logic                  shift_en_s, sclk_s, rise_s, fall_s;

    assign shift_en_s = (state_r == ST_SHIFT);

    spi_sclk_gen #(.CLKDIV(CLKDIV)) u_sclk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift_en_s),
        .sclk (sclk_s),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s  = state_r;
        tx_s     = tx_r;
        rx_s     = rx_r;
        rdata_s  = rdata_r;
        bitcnt_s = bitcnt_r;
        phase_s  = 8'd0;
        rw_s     = rw_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    tx_s     = {rw, addr, wdata};
                    rw_s     = rw;
                    rx_s     = {DATA_BITS{1'b0}};
                    bitcnt_s = 5'd0;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_r == PHASE_LAST) begin
                    state_s = ST_SHIFT;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (rise_s && rw_r && is_data_bit(bitcnt_r)) begin
                    rx_s = {rx_r[DATA_BITS-2:0], miso};
                end else begin
                    rx_s = rx_r;
                end
                if (fall_s) begin
                    tx_s     = {tx_r[FRAME_BITS-2:0], 1'b0};
                    bitcnt_s = bitcnt_r + 5'd1;
                    state_s  = (bitcnt_r == 5'(FRAME_BITS - 1)) ? ST_HOLD : ST_SHIFT;
                end else begin
                    state_s  = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (phase_r == PHASE_LAST) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    rdata_s = rw_r ? rx_r : rdata_r;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Read frames drive zeros through the data half regardless of wdata.
        mosi_s = ((state_s == ST_SETUP) || (state_s == ST_SHIFT)) && tx_s[FRAME_BITS-1]
                 && !(rw_s && is_data_bit(bitcnt_s));
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            tx_r     <= {FRAME_BITS{1'b0}};
            rx_r     <= {DATA_BITS{1'b0}};
            rdata_r  <= {DATA_BITS{1'b0}};
            bitcnt_r <= 5'd0;
            phase_r  <= 8'd0;
            rw_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cs_n_r   <= 1'b1;
            mosi_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            tx_r     <= tx_s;
            rx_r     <= rx_s;
            rdata_r  <= rdata_s;
            bitcnt_r <= bitcnt_s;
            phase_r  <= phase_s;
            rw_r     <= rw_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= done_s;
            cs_n_r   <= (state_s == ST_IDLE);
            mosi_r   <= mosi_s;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign rdata = rdata_r;
    assign sclk  = sclk_s;
    assign cs_n  = cs_n_r;
    assign mosi  = mosi_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: table of frames plus hand sequences, with an
// SPI slave model, a mosi frame capture and a done-driven scoreboard.
module tb_spi_master_ctrl;

    localparam int LAT4 = 1 + 34 * 4;
    localparam int LAT2 = 1 + 34 * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, rw, miso, busy, done, sclk, cs_n, mosi;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;

    logic       start2, rw2, miso2, busy2, done2, sclk2, cs2_n, mosi2;
    logic [6:0] addr2;
    logic [7:0] wdata2, rdata2;
    assign miso2 = 1'b1;

    spi_master_ctrl #(.CLKDIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .miso(miso), .busy(busy), .done(done), .rdata(rdata), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi)
    );

    spi_master_ctrl #(.CLKDIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .miso(miso2), .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2),
        .cs_n(cs2_n), .mosi(mosi2)
    );

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slave;
        logic [15:0] frame;
        logic [7:0] rd;
    } vec_t;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
        int          start_n;
    } exp_t;

    vec_t  vecs[7];
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc_n  = 0;
    int    nbits  = 0;
    int    falls  = 0;
    logic  sclk_q = 1'b0;
    logic [15:0] cap = 16'h0000;
    logic [7:0]  slave_val = 8'h00;
    logic [7:0]  last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One negedge: slave model, mosi capture at sclk rises, scoreboard on done.
    task automatic tick();
        exp_t       e;
        logic [2:0] idx;
        @(negedge clk);
        cyc_n++;
        if (cs_n) falls = 0;
        else if (sclk_q && !sclk) falls++;
        if (!cs_n && !sclk_q && sclk) begin
            cap = {cap[14:0], mosi};
            nbits++;
        end
        sclk_q = sclk;
        if (done) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame_bits", 32'(cap), 32'(e.frame));
                check("frame_len", 32'(nbits), 32'd16);
                check("rdata", 32'(rdata), 32'(e.rd));
                check("latency", 32'(cyc_n - e.start_n), 32'(LAT4));
                check("done_cs_n", 32'(cs_n), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
            end
        end
        if (cs_n) nbits = 0;
        idx  = 3'(15 - falls);
        miso = (!cs_n && falls >= 8 && falls < 16) ? slave_val[idx] : 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check("done_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] w,
                             input logic [7:0] s, input logic [15:0] fr, input logic [7:0] rd);
        start = 1'b1; rw = r; addr = a; wdata = w; slave_val = s;
        exp_q.push_back('{frame: fr, rd: rd, start_n: cyc_n});
        tick();
        start = 1'b0; rw = ~r; addr = ~a; wdata = ~w;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(LAT4 + 20);
        last_rd = rd;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00; miso = 1'b0;
        start2 = 1'b0; rw2 = 1'b0; addr2 = 7'h00; wdata2 = 8'h00;

        vecs[0] = '{1'b0, 7'h2A, 8'hC3, 8'h00, 16'h2AC3, 8'h00};
        vecs[1] = '{1'b1, 7'h05, 8'h00, 8'hA5, 16'h8500, 8'hA5};
        vecs[2] = '{1'b0, 7'h7F, 8'h5A, 8'h00, 16'h7F5A, 8'hA5};
        vecs[3] = '{1'b1, 7'h55, 8'hAA, 8'h00, 16'hD500, 8'h00};
        vecs[4] = '{1'b0, 7'h00, 8'hFF, 8'h00, 16'h00FF, 8'h00};
        vecs[5] = '{1'b0, 7'h01, 8'h80, 8'h00, 16'h0180, 8'h00};
        vecs[6] = '{1'b1, 7'h7F, 8'h99, 8'h3C, 16'hFF00, 8'h3C};

        repeat (3) tick();
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].slave,
                      vecs[i].frame, vecs[i].rd);
            repeat (3) tick();
        end

        // start while busy, with different inputs, must leave the frame alone
        start = 1'b1; rw = 1'b0; addr = 7'h12; wdata = 8'h34; slave_val = 8'h00;
        exp_q.push_back('{frame: 16'h1234, rd: last_rd, start_n: cyc_n});
        tick();
        start = 1'b0;
        repeat (19) tick();
        start = 1'b1; rw = 1'b1; addr = 7'h6B; wdata = 8'h00;
        tick();
        start = 1'b0;
        wait_done(LAT4 + 20);
        repeat (LAT4 + 10) tick();
        check("ignored_start_idle", 32'(busy), 32'd0);

        // start held through done: back-to-back frames, cs_n high one cycle
        start = 1'b1; rw = 1'b0; addr = 7'h33; wdata = 8'h0F;
        exp_q.push_back('{frame: 16'h330F, rd: last_rd, start_n: cyc_n});
        exp_q.push_back('{frame: 16'h330F, rd: last_rd, start_n: cyc_n + LAT4});
        k = 0;
        while (exp_q.size() == 2 && k < LAT4 + 20) begin
            tick();
            k++;
        end
        check("b2b_first_done", 32'(k), 32'(LAT4));
        check("b2b_cs_n_gap", 32'(cs_n), 32'd1);
        tick();
        check("b2b_cs_n_low", 32'(cs_n), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(LAT4 + 20);
        repeat (3) tick();

        // reset after the 5th sclk rise aborts the frame without done
        start = 1'b1; rw = 1'b0; addr = 7'h4C; wdata = 8'hE1;
        exp_q.push_back('{frame: 16'h4CE1, rd: last_rd, start_n: cyc_n});
        tick();
        start = 1'b0;
        k = 0;
        while (nbits < 5 && k < LAT4) begin
            tick();
            k++;
        end
        check("abort_at_5th_rise", 32'(nbits), 32'd5);
        exp_q.delete();
        rst_n = 1'b0;
        tick();
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", 32'(rdata), 32'h00);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        last_rd = 8'h00;
        repeat (LAT4 + 10) tick();
        run_frame(1'b0, 7'h4C, 8'hE1, 8'h00, 16'h4CE1, last_rd);

        // CLKDIV=2 instance: read of all-ones slave data
        start2 = 1'b1; rw2 = 1'b1; addr2 = 7'h11; wdata2 = 8'h00;
        tick();
        start2 = 1'b0;
        k = 1;
        while (!done2 && k < LAT2 + 20) begin
            tick();
            k++;
        end
        check("div2_latency", 32'(k), 32'(LAT2));
        check("div2_rdata", 32'(rdata2), 32'hFF);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLKDIV, default 4, meaning clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a transaction; sampled only while busy=0.
REQ-005 SHALL have port rw  input  1  1=read, 0=write; sampled with start.
REQ-006 SHALL have port addr  input  7  register address; sampled with start.
REQ-007 SHALL have port wdata  input  8  write data; sampled with start.
REQ-008 SHALL have port miso  input  1  serial data from slave; treated as already synchronous.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port rdata  output  8  last read result.
REQ-012 SHALL have port sclk  output  1  SPI clock, mode 0, idle low.
REQ-013 SHALL have port cs_n  output  1  active-low chip select.
REQ-014 SHALL have port mosi  output  1  serial data to slave.

Function
REQ-015 Frame SHALL be 16 bits, MSB first: rw, addr[6:0], then 8 data bits.
REQ-016 States SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-017 IDLE SHALL drive cs_n=1, sclk=0, mosi=0, busy=0; start=1 at an edge SHALL load the 16-bit tx shift register with {rw,addr,wdata} and enter SETUP.
REQ-018 SETUP SHALL drive cs_n=0, mosi=tx[15], sclk=0 for CLKDIV cycles, then enter SHIFT.
REQ-019 SHIFT SHALL toggle sclk every CLKDIV cycles, giving 16 full periods (32*CLKDIV cycles), starting with a rising edge.
REQ-020 On each sclk rising edge, for bits 8..15 with rw=1, miso SHALL be shifted into an 8-bit rx register, MSB first.
REQ-021 On each sclk falling edge, tx SHALL shift left one place and the 5-bit bit counter SHALL increment; after the 16th falling edge the block SHALL enter HOLD.
REQ-022 For rw=1, mosi SHALL be 0 during data bits 8..15.
REQ-023 HOLD SHALL keep cs_n=0, sclk=0 for CLKDIV cycles, then return to IDLE.
REQ-024 On HOLD-to-IDLE, cs_n SHALL rise and done SHALL pulse 1 cycle; rdata SHALL load rx on reads and stay unchanged on writes.
REQ-025 Latency from the start edge to done SHALL be 1+34*CLKDIV cycles (137 at CLKDIV=4).
REQ-026 start while busy=1 SHALL be ignored without side effects.
REQ-027 start in the done cycle SHALL be accepted, giving a minimum cs_n-high time of 1 cycle.
REQ-028 Inputs rw, addr and wdata SHALL be ignored after acceptance.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, and clear the counters and shift registers.
REQ-030 Reset mid-frame SHALL abort the transaction with no done pulse; the next start after release SHALL behave normally.

Structure
REQ-031 Shared header spi_defs SHALL hold the state encodings, FRAME_BITS=16, ADDR_BITS=7 and DATA_BITS=8.
REQ-032 A single sub-module, spi_sclk_gen, SHALL hold the half-period counter and emit one-cycle rise/fall strobes plus the registered sclk; it is enabled only in SHIFT.

Verification
REQ-033 Write, CLKDIV=4, rw=0, addr=0x2A, wdata=0xC3 -> mosi at the 16 rising edges = 0,0101010,11000011; done 137 cycles after the start edge; rdata unchanged.
REQ-034 Read, addr=0x05, slave model drives 0xA5 on bits 8..15 -> first mosi bit 1, mosi=0 during data bits, rdata=0xA5 in the done cycle.
REQ-035 start pulsed 20 cycles into a busy frame with different addr -> frame bits unchanged, exactly one done.
REQ-036 rst_n=0 for 1 cycle after the 5th rising edge -> next cycle cs_n=1, sclk=0, busy=0, rdata=0x00, no done; a new write then completes normally.
REQ-037 start held high through done -> second frame begins, cs_n high for exactly 1 cycle between frames.
REQ-038 CLKDIV=2, read with miso=1 -> rdata=0xFF, done 69 cycles after start.
